// File: rtl/tiny86_trace_checker.sv
// tiny86_trace_checker: verifies register continuity across a stream of tiny86 trace steps.
// Optional o_digest output is enabled by defining TRACE_CHK_DIGEST_EN.
module tiny86_fetch #(
  parameter int STEP_W = 560
) (
  input  logic [STEP_W-1:0] step,
  output logic [9:0][31:0]  pre,
  output logic [39:0]       ins
);
  logic unused_rsvd;
  assign pre = step[319:0];
  assign ins = step[359:320];
  assign unused_rsvd = ^step[STEP_W-1:360];
endmodule

module tiny86_core (
  input  logic [9:0][31:0] pre,
  input  logic [39:0]      ins,
  output logic [9:0][31:0] post
);
  // x86 register encoding (eax,ecx,edx,ebx,esp,ebp,esi,edi) to compare-mask order
  localparam logic [7:0][3:0] XMAP = {4'd5, 4'd4, 4'd7, 4'd6, 4'd1, 4'd3, 4'd2, 4'd0};
  logic [7:0] op, mb;
  logic [3:0] rd, rm, rg;
  logic [31:0] res, len;
  logic cy, flg, cfu;
  assign op = ins[7:0];
  assign mb = ins[15:8];
  assign rd = XMAP[op[2:0]];
  assign rm = XMAP[mb[2:0]];
  assign rg = XMAP[mb[5:3]];
  always_comb begin
    post = pre;
    res = '0;
    cy = 1'b0;
    flg = 1'b0;
    cfu = 1'b0;
    len = 32'd1;
    if (op[7:4] == 4'h4) begin
      res = op[3] ? pre[rd] - 32'd1 : pre[rd] + 32'd1;
      post[rd] = res;
      flg = 1'b1;
    end else if (op[7:3] == 5'b10111) begin
      post[rd] = ins[39:8];
      len = 32'd5;
    end else if ((op == 8'h01 || op == 8'h31) && mb[7:6] == 2'b11) begin
      {cy, res} = op[4] ? {1'b0, pre[rm] ^ pre[rg]} : {1'b0, pre[rm]} + {1'b0, pre[rg]};
      post[rm] = res;
      flg = 1'b1;
      cfu = 1'b1;
      len = 32'd2;
    end else if (op == 8'hEB) begin
      len = {{24{mb[7]}}, mb} + 32'd2;
    end
    if (flg) post[9] = {pre[9][31:8], res[31], res == 32'd0, pre[9][5:1], cfu ? cy : pre[9][0]};
    post[8] = pre[8] + len;
  end
endmodule

module tiny86_trace_checker #(
  parameter int          STEP_W   = 560,
  parameter int          CNT_W    = 32,
  parameter logic [9:0]  CMP_MASK = 10'h0FF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_step_valid,
  output logic              o_step_ready,
  input  logic [STEP_W-1:0] i_step,
  input  logic              i_last,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic              o_fail,
  output logic [CNT_W-1:0]  o_step_count,
  output logic [CNT_W-1:0]  o_fail_index,
`ifdef TRACE_CHK_DIGEST_EN
  output logic [31:0]       o_digest,
`endif
  output logic [9:0]        o_fail_regmask
);
  typedef enum logic [1:0] {IDLE, RUN, DONE, FAIL} state_t;
  state_t state;
  logic [9:0][31:0] pre, post, exp_q;
  logic [39:0] ins;
  logic [9:0] mm;
  logic acc, fin, ovf;
  tiny86_fetch #(.STEP_W(STEP_W)) u_fetch (.step(i_step), .pre(pre), .ins(ins));
  tiny86_core u_core (.pre(pre), .ins(ins), .post(post));
  assign acc = i_step_valid && o_step_ready;
  assign fin = i_clear && (state == DONE || state == FAIL);
  always_comb begin
    mm = '0;
    for (int i = 0; i < 10; i++) mm[i] = CMP_MASK[i] && (pre[i] != exp_q[i]);
  end
  // ovf marks that an accepted step could no longer be counted; the next accept is an overflow
  always_ff @(posedge clk) begin
    if (rst || fin) begin
      state <= IDLE;
      o_step_ready <= 1'b1;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_pass <= 1'b0;
      o_fail <= 1'b0;
      o_step_count <= '0;
      o_fail_index <= '0;
      o_fail_regmask <= '0;
      exp_q <= '0;
      ovf <= 1'b0;
    end else if (acc) begin
      if (state == RUN && (ovf || |mm)) begin
        state <= FAIL;
        o_step_ready <= 1'b0;
        o_busy <= 1'b0;
        o_done <= 1'b1;
        o_fail <= 1'b1;
        o_fail_index <= ovf ? '1 : o_step_count;
        o_fail_regmask <= ovf ? '0 : mm;
      end else begin
        exp_q <= post;
        if (&o_step_count) ovf <= 1'b1;
        else o_step_count <= o_step_count + CNT_W'(1);
        state <= i_last ? DONE : RUN;
        o_step_ready <= !i_last;
        o_busy <= !i_last;
        o_done <= i_last;
        o_pass <= i_last;
      end
    end
  end
`ifdef TRACE_CHK_DIGEST_EN
  localparam int NW = (STEP_W + 31) / 32;
  logic [32*NW-1:0] pad;
  logic [31:0] fold;
  always_comb begin
    pad = (32*NW)'(i_step);
    fold = '0;
    for (int i = 0; i < NW; i++) fold = fold ^ pad[32*i +: 32];
  end
  always_ff @(posedge clk) begin
    if (rst || fin) o_digest <= '0;
    else if (acc) o_digest <= {o_digest[30:0], o_digest[31]} ^ fold;
  end
`endif
endmodule

// File: tb/tb_tiny86_trace_checker.sv
// tb_tiny86_trace_checker: directed scoreboard bench over three checker configurations.
module tb_tiny86_trace_checker;
  typedef logic [9:0][31:0] regs_t;
  typedef struct {
    int d;
    logic pass;
    logic fail;
    logic [31:0] cnt;
    logic [31:0] idx;
    logic [9:0] mask;
  } vr_t;
  typedef struct {
    logic r, b, dn, p, f;
    logic [31:0] n, x;
    logic [9:0] m;
  } snap_t;

  logic clk = 1'b0, rst = 1'b1, i_clear = 1'b0, i_last = 1'b0;
  logic v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic [559:0] i_step = '0;
  logic r0, b0, d0, p0, f0, r1, b1, d1, p1, f1, r2, b2, d2, p2, f2;
  logic [31:0] n0, x0, n1, x1;
  logic [1:0] n2, x2;
  logic [9:0] m0, m1, m2;
`ifdef TRACE_CHK_DIGEST_EN
  logic [31:0] g0, g1, g2;
`endif
  int checks = 0, failures = 0;
  int xm[8] = '{0, 2, 3, 1, 6, 7, 4, 5};
  vr_t sbq[$];

  always #5 clk = ~clk;

  tiny86_trace_checker u0 (
    .clk(clk), .rst(rst), .i_clear(i_clear), .i_step_valid(v0), .o_step_ready(r0),
    .i_step(i_step), .i_last(i_last), .o_busy(b0), .o_done(d0), .o_pass(p0), .o_fail(f0),
    .o_step_count(n0), .o_fail_index(x0),
`ifdef TRACE_CHK_DIGEST_EN
    .o_digest(g0),
`endif
    .o_fail_regmask(m0));
  tiny86_trace_checker #(.CMP_MASK(10'h3FF)) u1 (
    .clk(clk), .rst(rst), .i_clear(i_clear), .i_step_valid(v1), .o_step_ready(r1),
    .i_step(i_step), .i_last(i_last), .o_busy(b1), .o_done(d1), .o_pass(p1), .o_fail(f1),
    .o_step_count(n1), .o_fail_index(x1),
`ifdef TRACE_CHK_DIGEST_EN
    .o_digest(g1),
`endif
    .o_fail_regmask(m1));
  tiny86_trace_checker #(.CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .i_clear(i_clear), .i_step_valid(v2), .o_step_ready(r2),
    .i_step(i_step), .i_last(i_last), .o_busy(b2), .o_done(d2), .o_pass(p2), .o_fail(f2),
    .o_step_count(n2), .o_fail_index(x2),
`ifdef TRACE_CHK_DIGEST_EN
    .o_digest(g2),
`endif
    .o_fail_regmask(m2));

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic snap_t snap(input int d);
    snap_t s;
    if (d == 0) s = '{r0, b0, d0, p0, f0, n0, x0, m0};
    else if (d == 1) s = '{r1, b1, d1, p1, f1, n1, x1, m1};
    else s = '{r2, b2, d2, p2, f2, 32'(n2), 32'(x2), m2};
    return s;
  endfunction

  // reference tiny86 semantics for the handful of opcodes the traces use
  function automatic regs_t model(input regs_t p, input logic [119:0] w);
    regs_t q = p;
    logic [7:0] op = w[7:0];
    logic [7:0] m = w[15:8];
    logic [31:0] r = '0, nip;
    logic c = 1'b0;
    bit fl = 0, cu = 0;
    int a = xm[m[2:0]], b = xm[m[5:3]], d = xm[op[2:0]];
    nip = p[8] + 32'd1;
    if (op >= 8'h40 && op <= 8'h47) begin r = p[d] + 32'd1; q[d] = r; fl = 1; end
    else if (op >= 8'h48 && op <= 8'h4F) begin r = p[d] - 32'd1; q[d] = r; fl = 1; end
    else if (op >= 8'hB8 && op <= 8'hBF) begin q[d] = w[39:8]; nip = p[8] + 32'd5; end
    else if (op == 8'h01 && m[7:6] == 2'b11) begin
      {c, r} = {1'b0, p[a]} + {1'b0, p[b]}; q[a] = r; fl = 1; cu = 1; nip = p[8] + 32'd2;
    end else if (op == 8'h31 && m[7:6] == 2'b11) begin
      r = p[a] ^ p[b]; c = 1'b0; q[a] = r; fl = 1; cu = 1; nip = p[8] + 32'd2;
    end else if (op == 8'hEB) nip = p[8] + 32'd2 + {{24{m[7]}}, m};
    if (fl) begin
      q[9][7] = r[31];
      q[9][6] = (r == 32'd0);
      if (cu) q[9][0] = c;
    end
    q[8] = nip;
    return q;
  endfunction

  function automatic logic [119:0] ins_at(input int k);
    logic [119:0] w = '0;
    case (k % 5)
      0: w[39:0] = {$urandom, 8'hB8};
      1: w[7:0] = 8'h41;
      2: w[15:0] = 16'hC301;
      3: w[15:0] = 16'hD131;
      default: w[15:0] = {8'($urandom_range(0, 255)), 8'hEB};
    endcase
    return w;
  endfunction

  task automatic gen(output logic [559:0] tr [6]);
    regs_t st;
    logic [119:0] w;
    logic [127:0] rr;
    for (int i = 0; i < 10; i++) st[i] = $urandom;
    for (int k = 0; k < 6; k++) begin
      w = ins_at(k);
      rr = {$urandom, $urandom, $urandom, $urandom};
      tr[k] = {rr[119:0], w, st};
      st = model(st, w);
    end
  endtask

  task automatic drive(input logic [2:0] vm, input logic [559:0] s, input logic l);
    @(negedge clk);
    {v2, v1, v0} = vm;
    i_step = s;
    i_last = l;
  endtask

  task automatic idle();
    @(negedge clk);
    {v2, v1, v0} = 3'b000;
    i_last = 1'b0;
  endtask

  task automatic clear();
    @(negedge clk);
    {v2, v1, v0} = 3'b000;
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
  endtask

  task automatic push(input int d, input logic ps, input logic fl, input int cnt, input int idx,
                      input logic [9:0] mask);
    vr_t e;
    e = '{d, ps, fl, cnt, idx, mask};
    sbq.push_back(e);
  endtask

  task automatic check_idle(input int d);
    snap_t s = snap(d);
    string t = $sformatf("idle%0d_", d);
    chk({t, "ready"}, 32'(s.r), 1);
    chk({t, "busy"}, 32'(s.b), 0);
    chk({t, "done"}, 32'(s.dn), 0);
    chk({t, "pass"}, 32'(s.p), 0);
    chk({t, "fail"}, 32'(s.f), 0);
    chk({t, "count"}, s.n, 0);
    chk({t, "index"}, s.x, 0);
    chk({t, "regmask"}, 32'(s.m), 0);
  endtask

  task automatic wait_verdict(input int d);
    snap_t s = snap(d);
    vr_t e;
    string t = $sformatf("verdict%0d_", d);
    int n = 0;
    while (!s.dn && n < 10) begin
      @(negedge clk);
      n++;
      s = snap(d);
    end
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard observed=empty expected=entry", t);
      return;
    end
    e = sbq.pop_front();
    chk({t, "done"}, 32'(s.dn), 1);
    chk({t, "pass"}, 32'(s.p), 32'(e.pass));
    chk({t, "fail"}, 32'(s.f), 32'(e.fail));
    chk({t, "count"}, s.n, e.cnt);
    chk({t, "index"}, s.x, e.idx);
    chk({t, "regmask"}, 32'(s.m), 32'(e.mask));
    chk({t, "ready"}, 32'(s.r), 0);
    chk({t, "busy"}, 32'(s.b), 0);
  endtask

  initial begin
    logic [559:0] tr [6];
    snap_t s;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) check_idle(d);

    // single step with last
    gen(tr);
    drive(3'b001, tr[0], 1'b1);
    push(0, 1, 0, 1, 0, 10'h000);
    idle();
    wait_verdict(0);
    clear();
    check_idle(0);

    // four consistent back-to-back steps
    gen(tr);
    for (int k = 0; k < 4; k++) begin
      drive(3'b001, tr[k], k == 3);
      if (k > 0) begin
        s = snap(0);
        chk($sformatf("run_count%0d", k), s.n, k);
        chk($sformatf("run_ready%0d", k), 32'(s.r), 1);
        chk($sformatf("run_busy%0d", k), 32'(s.b), 1);
      end
    end
    push(0, 1, 0, 4, 0, 10'h000);
    idle();
    wait_verdict(0);
    clear();

    // ecx off by one in step 2
    gen(tr);
    tr[2][64 +: 32] = tr[2][64 +: 32] + 32'd1;
    for (int k = 0; k < 3; k++) drive(3'b001, tr[k], k == 2);
    push(0, 0, 1, 2, 2, 10'h004);
    idle();
    wait_verdict(0);
    clear();
    check_idle(0);

    // eflags-only mismatch: masked out by default, caught with full mask
    gen(tr);
    tr[1][288 +: 32] = tr[1][288 +: 32] ^ 32'h1;
    drive(3'b011, tr[0], 1'b0);
    drive(3'b011, tr[1], 1'b1);
    push(0, 1, 0, 2, 0, 10'h000);
    push(1, 0, 1, 1, 1, 10'h200);
    idle();
    wait_verdict(0);
    wait_verdict(1);
    clear();
    check_idle(1);

    // reset mid-trace, then next step starts a fresh trace
    gen(tr);
    drive(3'b001, tr[0], 1'b0);
    drive(3'b001, tr[1], 1'b0);
    @(negedge clk);
    {v2, v1, v0} = 3'b000;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle(0);
    drive(3'b001, tr[2], 1'b1);
    push(0, 1, 0, 1, 0, 10'h000);
    idle();
    wait_verdict(0);
    clear();
    check_idle(0);

    // 2-bit counter saturation and overflow
    gen(tr);
    for (int k = 0; k < 5; k++) begin
      drive(3'b100, tr[k], 1'b0);
      if (k >= 3) begin
        s = snap(2);
        chk($sformatf("sat_count%0d", k), s.n, 3);
        chk($sformatf("sat_fail%0d", k), 32'(s.f), 0);
        chk($sformatf("sat_busy%0d", k), 32'(s.b), 1);
      end
    end
    push(2, 0, 1, 3, 3, 10'h000);
    idle();
    wait_verdict(2);
    clear();
    check_idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tiny86_trace_checker.md
Name: tiny86_trace_checker

Overview:
Sequential, multi-step successor to the single-step tiny86 checker. Consumes a stream of 560-bit trace steps over a valid/ready handshake. Each step is run through an internal tiny86 instance, and the computed post-state is registered. Each following step's pre-state (extracted by an internal fetch instance) is compared against that registered post-state, so a whole trace is verified for register continuity and a pass/fail verdict is reported.

Parameters:
STEP_W, 560, trace step width in bits; must match the tiny86/fetch step layout.
CNT_W, 32, width of the step counter and the failure index.
CMP_MASK, 10'h0FF, per-register compare enable. Bit order: 0 eax, 1 ebx, 2 ecx, 3 edx, 4 esi, 5 edi, 6 esp, 7 ebp, 8 eip, 9 eflags. The default excludes eip and eflags.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
i_clear  input  1  single-cycle pulse; returns the block from DONE or FAIL to IDLE.
i_step_valid  input  1  a step is presented on i_step.
o_step_ready  output  1  block can accept a step this cycle.
i_step  input  STEP_W  trace step.
i_last  input  1  qualifies i_step as the final step of the trace.
o_busy  output  1  state is RUN.
o_done  output  1  trace finished (pass or fail); level signal.
o_pass  output  1  trace verified; valid while o_done=1.
o_fail  output  1  mismatch or overflow detected; valid while o_done=1.
o_step_count  output  CNT_W  number of steps accepted since IDLE; saturating.
o_fail_index  output  CNT_W  0-based index of the step whose pre-state mismatched.
o_fail_regmask  output  10  mismatching registers, masked by CMP_MASK, using CMP_MASK bit order.

Behaviour:
- States and transitions:
  - IDLE: waiting for the first step.
  - RUN: at least one step accepted.
  - DONE: terminal, pass.
  - FAIL: terminal, fail.
- Reset values:
  - State = IDLE.
  - Every output is 0 except o_step_ready = 1.
  - Expected-state registers = 0.
  - Reset asserted mid-trace aborts it with no verdict.
- Handshake:
  - o_step_ready = 1 in IDLE and RUN; 0 in DONE and FAIL.
  - A step is accepted when i_step_valid && o_step_ready.
  - i_step and i_last are sampled only on acceptance.
  - No backpressure inside a trace: throughput is one step per cycle.
- Accept in IDLE:
  - Register the tiny86 outputs into the expected-state registers; count becomes 1.
  - No compare is performed.
  - If i_last=1: go to DONE with o_pass=1. Otherwise go to RUN.
- Accept in RUN:
  - Compare the 10 fetched pre-state registers against the expected registers, ANDed with CMP_MASK.
  - Any mismatch:
    - Go to FAIL.
    - o_fail_index = pre-increment count.
    - o_fail_regmask = mismatch bits.
    - Expected registers are not updated.
  - No mismatch:
    - Update the expected registers from this step's tiny86 outputs; count += 1.
    - If i_last=1: go to DONE with o_pass=1.
- Latency: the verdict (o_done, o_pass/o_fail) is visible the cycle after the accepting edge.
- Saturation:
  - o_step_count saturates at 2^CNT_W-1.
  - Accepting a step while the count is saturated goes to FAIL with o_fail_regmask=0 and o_fail_index=all-ones (overflow).
- i_clear:
  - In DONE or FAIL: go to IDLE and clear the count, verdict, fail fields and expected registers.
  - Ignored in IDLE and RUN.
  - i_clear together with an accepted step is impossible, since ready=0 in DONE/FAIL.
  - rst has priority over i_clear.
- o_pass and o_fail are mutually exclusive and only ever set together with o_done.

Optional Feature:
Macro: TRACE_CHK_DIGEST_EN.
- Defined:
  - Adds output o_digest [31:0], reset to 0.
  - On each accepted step: o_digest <= {o_digest[30:0], o_digest[31]} ^ XOR-fold of the 32-bit words of i_step. A partial top word is zero-extended.
  - o_digest is cleared by i_clear and held in DONE and FAIL.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Single step, i_last=1 -> next cycle o_done=1, o_pass=1, o_step_count=1, o_step_ready=0.
- 4 consistent steps: each pre-state equals the previous post-state, valid held high, last on step 3 -> accepted on 4 consecutive cycles, o_pass=1, o_step_count=4.
- 3 steps, step 2 pre-state ecx off by 1 -> o_fail=1, o_fail_index=2, o_fail_regmask=10'h004, o_step_count=2.
- Mismatch only in eflags with default CMP_MASK -> no failure, o_pass=1. Same trace with CMP_MASK=10'h3FF -> o_fail_regmask=10'h200.
- rst asserted after 2 of 5 steps -> all outputs 0, o_step_ready=1, next step treated as first. Later, after a verdict: i_clear pulse -> IDLE, o_done=0, count=0.
- CNT_W=2, 5 consistent steps with no last -> 4th accept saturates count at 3, 5th accept -> o_fail=1, o_fail_regmask=0, o_fail_index=3.
